fifo_packer: RTL and testbench
==============================

Name: fifo_packer

Overview:
Width-converting stage between two handshake FIFOs. Pops IN_WIDTH-bit elements from an upstream fifo, packs RATIO consecutive elements into one OUT_WIDTH word, and pushes the word into a downstream fifo. Sits on the node/ray streaming path, where narrow quantized fields are grouped into wide words. A flush request emits a zero-padded partial word.

Parameters:
IN_WIDTH, 8, width of one upstream element
RATIO, 4, elements per output word (>=2)
OUT_WIDTH, IN_WIDTH*RATIO, derived; do not override
LANE_W, $clog2(RATIO+1), derived width of lane count

Ports:
clk  input  1  clock
arst_n  input  1  asynchronous active-low reset
in_empty_n  input  1  upstream fifo has data
in_read  output  1  pop upstream element this cycle
in_dout  input  IN_WIDTH  upstream head element
out_full_n  input  1  downstream fifo can accept
out_write  output  1  packed word valid (push when out_full_n)
out_din  output  OUT_WIDTH  packed word
out_lanes  output  LANE_W  number of valid lanes in out_din (1..RATIO)
flush  input  1  request to emit partial word; held until flush_ack
flush_ack  output  1  one-cycle pulse: flush accepted

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (arst_n).
- Reset: state FILL, cnt=0, shift register cleared, out_write=0, out_din=0, out_lanes=0, flush_ack=0. A reset asserted mid-operation discards the partial or pending word.
- Transfer rules: upstream pop occurs when in_read & in_empty_n. Downstream push occurs when out_write & out_full_n.
- Lane order: the first element is placed in out_din[IN_WIDTH-1:0], and element k in bits [k*IN_WIDTH +: IN_WIDTH]. Unfilled lanes are 0.
- State FILL (cnt 0..RATIO-1):
  - in_read = in_empty_n (combinational).
  - On pop: lane[cnt] <= in_dout, cnt <= cnt+1.
  - If cnt+1 == RATIO: go to HOLD with out_lanes=RATIO.
  - flush_ack = flush (combinational, FILL only).
  - Let n = cnt + pop. If flush and n>0: go to HOLD with out_lanes=n. A simultaneous pop is included in the flushed word.
  - If flush and n==0: ack only; no word is produced.
- State HOLD:
  - out_write=1. out_din and out_lanes stay stable until the push.
  - in_read = in_empty_n & out_full_n, so an input element can be taken in the same cycle the word drains.
  - On push with no pop: lanes cleared, cnt=0, go to FILL.
  - On push with a pop: lane0 <= in_dout, other lanes 0, cnt=1, go to FILL. This gives a bubble-free stream.
  - flush is ignored in HOLD (flush_ack=0); the requester keeps it held.
- Latency: out_write asserts the cycle after the pop that completes the word, or after the flush is accepted.
- Throughput: one input element per cycle sustained while out_full_n=1. Output rate is one word every RATIO cycles.
- The block never pops into a full buffer and never drops a word under backpressure.

Optional Feature:
Macro: FIFO_PACKER_STATS_EN
- Defined:
  - Adds int counters total_cycle_count, pop_count, push_count and flush_word_count (partial words only).
  - Counters reset on arst_n.
  - A final block prints "[%m]: pops: X, pushes: Y, partial: Z / cycles: T".
- Undefined: no counters and no final statements. Ports and timing are identical in both builds.

Decomposition:
- Package stream_pkg holds:
  - typedef enum logic {FILL, HOLD} packer_state_t;
  - a function lane_w(ratio) returning $clog2(ratio+1).
- No sub-module: the lane register array and the counter form one small always_ff plus a combinational handshake block.
- The bench wraps the DUT between two existing fifo instances, IN_WIDTH upstream and OUT_WIDTH+LANE_W downstream.

Test Plan:
- Full word: push 0x11,0x22,0x33,0x44 with out_full_n=1. Required: out_write one cycle after the 4th pop, out_din=0x44332211, out_lanes=4.
- Back-to-back stream: push 8 elements 0x01..0x08 continuously. Required:
  - in_read high for 8 consecutive cycles;
  - words 0x04030201 then 0x08070605;
  - no input bubble at the HOLD->FILL boundary.
- Backpressure: complete a word, then hold out_full_n=0 for 5 cycles. Required:
  - out_write stays 1 and out_din stays stable;
  - in_read=0;
  - when out_full_n rises, exactly one push occurs, with a simultaneous pop of the next element.
- Flush: push 0xAA,0xBB, then raise flush. Required: flush_ack pulses, out_din=0x0000BBAA, out_lanes=2. Flush with cnt=0 and no pop: ack only, no out_write.
- Flush+pop: at cnt=2, raise flush in the same cycle as popping 0xCC. Required: out_lanes=3, out_din lane2=0xCC. Flush raised during HOLD: no ack until the word drains.
- Reset mid-HOLD: assert arst_n=0 while out_write=1. Required: out_write=0 immediately. After release, a fresh 4-element word packs from lane0.

Source files
------------

// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_pkg
//  Description : Shared types and helpers for the node/ray streaming path.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

    // Packer control state: filling lanes, or holding a finished word.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_t;

    // Width needed to count 0..ratio valid lanes.
    function automatic int lane_w(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_packer
//  Description : Pops IN_WIDTH-bit elements from an upstream FIFO, packs
//                RATIO of them (first element in the low lane) into one
//                OUT_WIDTH word and pushes it downstream. A flush request
//                emits a zero-padded partial word with its lane count.
//                Optional statistics: define FIFO_PACKER_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_packer
    import stream_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int RATIO     = 4,
    parameter int OUT_WIDTH = IN_WIDTH * RATIO,
    parameter int LANE_W    = lane_w(RATIO)
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 in_empty_n,
    output logic                 in_read,
    input  logic [IN_WIDTH-1:0]  in_dout,
    input  logic                 out_full_n,
    output logic                 out_write,
    output logic [OUT_WIDTH-1:0] out_din,
    output logic [LANE_W-1:0]    out_lanes,
    input  logic                 flush,
    output logic                 flush_ack
);

    packer_state_t          state_q, state_d;
    logic [LANE_W-1:0]      cnt_q, cnt_d;
    logic [LANE_W-1:0]      lanes_q, lanes_d;
    logic [OUT_WIDTH-1:0]   data_q, data_d;
    logic                   w_pop;
    logic                   w_push;
    logic [LANE_W-1:0]      w_fill_n;

    assign w_pop    = in_read & in_empty_n;
    assign w_push   = out_write & out_full_n;
    // Lanes that would be occupied after this cycle's pop (if any).
    assign w_fill_n = cnt_q + LANE_W'(w_pop);

    assign out_din   = data_q;
    assign out_lanes = lanes_q;

    // Handshake: HOLD only accepts input when the word drains in the same cycle.
    always_comb begin
        in_read   = 1'b0;
        out_write = 1'b0;
        flush_ack = 1'b0;
        case (state_q)
            FILL: begin
                in_read   = in_empty_n;
                flush_ack = flush;
            end
            HOLD: begin
                in_read   = in_empty_n & out_full_n;
                out_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state: lane insertion, word completion, flush and drain.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lanes_d = lanes_q;
        data_d  = data_q;
        case (state_q)
            FILL: begin
                if (w_pop) begin
                    for (int i = 0; i < RATIO; i++) begin
                        if (cnt_q == LANE_W'(i)) begin
                            data_d[i*IN_WIDTH +: IN_WIDTH] = in_dout;
                        end
                    end
                    cnt_d = w_fill_n;
                end
                // A pop coinciding with flush is part of the flushed word.
                if ((w_pop && (cnt_q == LANE_W'(RATIO - 1))) ||
                    (flush && (w_fill_n != '0))) begin
                    state_d = HOLD;
                    lanes_d = w_fill_n;
                end
            end
            HOLD: begin
                if (w_push) begin
                    state_d = FILL;
                    lanes_d = '0;
                    data_d  = '0;
                    cnt_d   = '0;
                    // Take the next element while draining: no input bubble.
                    if (w_pop) begin
                        data_d[IN_WIDTH-1:0] = in_dout;
                        cnt_d                = LANE_W'(1);
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State registers; reset discards any partial or pending word.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            lanes_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
            data_q  <= data_d;
        end
    end

`ifdef FIFO_PACKER_STATS_EN
    int total_cycle_count;
    int pop_count;
    int push_count;
    int flush_word_count;

    // Activity counters; a partial word is one that enters HOLD short of RATIO lanes.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            total_cycle_count <= 0;
            pop_count         <= 0;
            push_count        <= 0;
            flush_word_count  <= 0;
        end else begin
            total_cycle_count <= total_cycle_count + 1;
            if (w_pop)  pop_count  <= pop_count + 1;
            if (w_push) push_count <= push_count + 1;
            if ((state_q == FILL) && (state_d == HOLD) &&
                (lanes_d != LANE_W'(RATIO))) begin
                flush_word_count <= flush_word_count + 1;
            end
        end
    end

    final begin
        $display("[%m]: pops: %0d, pushes: %0d, partial: %0d / cycles: %0d",
                 pop_count, push_count, flush_word_count, total_cycle_count);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_packer
//  Description : Directed, table-driven bench for fifo_packer (8-bit x 4).
//                Each vector drives one cycle of handshake inputs and states
//                the outputs expected during that cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_packer;

    localparam int IN_WIDTH  = 8;
    localparam int RATIO     = 4;
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int LANE_W    = 3;

    logic                 clk;
    logic                 arst_n;
    logic                 in_empty_n;
    logic                 in_read;
    logic [IN_WIDTH-1:0]  in_dout;
    logic                 out_full_n;
    logic                 out_write;
    logic [OUT_WIDTH-1:0] out_din;
    logic [LANE_W-1:0]    out_lanes;
    logic                 flush;
    logic                 flush_ack;

    int checks;
    int failures;

    typedef struct {
        logic                 e;
        logic [IN_WIDTH-1:0]  d;
        logic                 ff;
        logic                 fl;
        logic                 rd;
        logic                 w;
        logic [OUT_WIDTH-1:0] din;
        logic [LANE_W-1:0]    lanes;
        logic                 ack;
    } vec_t;

    vec_t vecs[$];

    fifo_packer #(
        .IN_WIDTH (IN_WIDTH),
        .RATIO    (RATIO)
    ) u_dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .in_empty_n (in_empty_n),
        .in_read    (in_read),
        .in_dout    (in_dout),
        .out_full_n (out_full_n),
        .out_write  (out_write),
        .out_din    (out_din),
        .out_lanes  (out_lanes),
        .flush      (flush),
        .flush_ack  (flush_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic e, input logic [7:0] d, input logic ff,
                       input logic fl, input logic rd, input logic w,
                       input logic [31:0] din, input logic [2:0] lanes,
                       input logic ack);
        vec_t v;
        v.e = e; v.d = d; v.ff = ff; v.fl = fl;
        v.rd = rd; v.w = w; v.din = din; v.lanes = lanes; v.ack = ack;
        vecs.push_back(v);
    endtask

    // Drive one vector after the falling edge and check outputs before the next rising edge.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        in_empty_n = v.e;
        in_dout    = v.d;
        out_full_n = v.ff;
        flush      = v.fl;
        #1;
        checks++;
        if (in_read !== v.rd || out_write !== v.w || out_din !== v.din ||
            out_lanes !== v.lanes || flush_ack !== v.ack) begin
            failures++;
            $display("FAIL %s got rd=%b w=%b din=%08h lanes=%0d ack=%b exp rd=%b w=%b din=%08h lanes=%0d ack=%b",
                     name, in_read, out_write, out_din, out_lanes, flush_ack,
                     v.rd, v.w, v.din, v.lanes, v.ack);
        end
    endtask

    task automatic apply_queue(input string name);
        foreach (vecs[i]) apply(vecs[i], $sformatf("%s[%0d]", name, i));
        vecs.delete();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        arst_n     = 1'b0;
        in_empty_n = 1'b0;
        in_dout    = '0;
        out_full_n = 1'b1;
        flush      = 1'b0;

        // Reset state.
        #2;
        checks++;
        if (in_read !== 1'b0 || out_write !== 1'b0 || out_din !== 32'h0 ||
            out_lanes !== 3'd0 || flush_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset got rd=%b w=%b din=%08h lanes=%0d ack=%b exp all zero",
                     in_read, out_write, out_din, out_lanes, flush_ack);
        end
        @(negedge clk);
        arst_n = 1'b1;

        //   e  d      ff fl  rd w  din           lanes ack
        // Full word 11..44
        add(1, 8'h11, 1, 0,  1, 0, 32'h00000000, 0, 0);
        add(1, 8'h22, 1, 0,  1, 0, 32'h00000011, 0, 0);
        add(1, 8'h33, 1, 0,  1, 0, 32'h00002211, 0, 0);
        add(1, 8'h44, 1, 0,  1, 0, 32'h00332211, 0, 0);
        add(0, 8'h00, 1, 0,  0, 1, 32'h44332211, 4, 0);
        add(0, 8'h00, 1, 0,  0, 0, 32'h00000000, 0, 0);
        // Back-to-back 01..08, pop continues through the drain cycle
        add(1, 8'h01, 1, 0,  1, 0, 32'h00000000, 0, 0);
        add(1, 8'h02, 1, 0,  1, 0, 32'h00000001, 0, 0);
        add(1, 8'h03, 1, 0,  1, 0, 32'h00000201, 0, 0);
        add(1, 8'h04, 1, 0,  1, 0, 32'h00030201, 0, 0);
        add(1, 8'h05, 1, 0,  1, 1, 32'h04030201, 4, 0);
        add(1, 8'h06, 1, 0,  1, 0, 32'h00000005, 0, 0);
        add(1, 8'h07, 1, 0,  1, 0, 32'h00000605, 0, 0);
        add(1, 8'h08, 1, 0,  1, 0, 32'h00070605, 0, 0);
        add(0, 8'h00, 1, 0,  0, 1, 32'h08070605, 4, 0);
        // Backpressure: 5 stalled cycles, then push with simultaneous pop of 0x14
        add(1, 8'h10, 1, 0,  1, 0, 32'h00000000, 0, 0);
        add(1, 8'h11, 1, 0,  1, 0, 32'h00000010, 0, 0);
        add(1, 8'h12, 1, 0,  1, 0, 32'h00001110, 0, 0);
        add(1, 8'h13, 1, 0,  1, 0, 32'h00121110, 0, 0);
        for (int k = 0; k < 5; k++)
            add(1, 8'h14, 0, 0,  0, 1, 32'h13121110, 4, 0);
        add(1, 8'h14, 1, 0,  1, 1, 32'h13121110, 4, 0);
        add(0, 8'h00, 1, 0,  0, 0, 32'h00000014, 0, 0);
        // Flush the single leftover lane
        add(0, 8'h00, 1, 1,  0, 0, 32'h00000014, 0, 1);
        add(0, 8'h00, 1, 0,  0, 1, 32'h00000014, 1, 0);
        // Flush after AA,BB; then flush with nothing buffered (ack only)
        add(1, 8'hAA, 1, 0,  1, 0, 32'h00000000, 0, 0);
        add(1, 8'hBB, 1, 0,  1, 0, 32'h000000AA, 0, 0);
        add(0, 8'h00, 1, 1,  0, 0, 32'h0000BBAA, 0, 1);
        add(0, 8'h00, 1, 0,  0, 1, 32'h0000BBAA, 2, 0);
        add(0, 8'h00, 1, 1,  0, 0, 32'h00000000, 0, 1);
        add(0, 8'h00, 1, 0,  0, 0, 32'h00000000, 0, 0);
        // Flush coinciding with pop of CC; flush held through HOLD gets no ack
        add(1, 8'h01, 1, 0,  1, 0, 32'h00000000, 0, 0);
        add(1, 8'h02, 1, 0,  1, 0, 32'h00000001, 0, 0);
        add(1, 8'hCC, 1, 1,  1, 0, 32'h00000201, 0, 1);
        add(1, 8'hDD, 0, 1,  0, 1, 32'h00CC0201, 3, 0);
        add(0, 8'h00, 1, 1,  0, 1, 32'h00CC0201, 3, 0);
        add(0, 8'h00, 1, 1,  0, 0, 32'h00000000, 0, 1);
        add(0, 8'h00, 1, 0,  0, 0, 32'h00000000, 0, 0);
        apply_queue("vec");

        // Reset while a word is held under backpressure.
        add(1, 8'h21, 1, 0,  1, 0, 32'h00000000, 0, 0);
        add(1, 8'h22, 1, 0,  1, 0, 32'h00000021, 0, 0);
        add(1, 8'h23, 1, 0,  1, 0, 32'h00002221, 0, 0);
        add(1, 8'h24, 1, 0,  1, 0, 32'h00232221, 0, 0);
        add(1, 8'h25, 0, 0,  0, 1, 32'h24232221, 4, 0);
        apply_queue("prerst");
        #2;
        arst_n = 1'b0;
        #1;
        checks++;
        if (out_write !== 1'b0 || out_din !== 32'h0 || out_lanes !== 3'd0) begin
            failures++;
            $display("FAIL midrst got w=%b din=%08h lanes=%0d exp w=0 din=00000000 lanes=0",
                     out_write, out_din, out_lanes);
        end
        @(negedge clk);
        in_empty_n = 1'b0;
        out_full_n = 1'b1;
        arst_n     = 1'b1;
        add(1, 8'h31, 1, 0,  1, 0, 32'h00000000, 0, 0);
        add(1, 8'h32, 1, 0,  1, 0, 32'h00000031, 0, 0);
        add(1, 8'h33, 1, 0,  1, 0, 32'h00003231, 0, 0);
        add(1, 8'h34, 1, 0,  1, 0, 32'h00333231, 0, 0);
        add(0, 8'h00, 1, 0,  0, 1, 32'h34333231, 4, 0);
        add(0, 8'h00, 1, 0,  0, 0, 32'h00000000, 0, 0);
        apply_queue("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
